// File: rtl/pr_bus_arbiter_pkg.sv
// Shared types and defaults for the peripheral bus arbiter: FSM encoding,
// master ids, default device windows and address helpers.
package pr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam logic [31:0] DEV0_BASE_DEF  = 32'h0000_7F00;
  localparam logic [31:0] DEV0_LIMIT_DEF = 32'h0000_7F0B;
  localparam logic [31:0] DEV1_BASE_DEF  = 32'h0000_7F10;
  localparam logic [31:0] DEV1_LIMIT_DEF = 32'h0000_7F1B;
  localparam int unsigned TIMEOUT_DEF    = 15;

  // Device-side address is always the containing word.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pr_bus_arbiter_addr_decode.sv
// Combinational address decode: inclusive window hits for both devices
// plus a word-misalignment flag.
module pr_addr_decode
  import pr_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE  = DEV0_BASE_DEF,
  parameter logic [31:0] DEV0_LIMIT = DEV0_LIMIT_DEF,
  parameter logic [31:0] DEV1_BASE  = DEV1_BASE_DEF,
  parameter logic [31:0] DEV1_LIMIT = DEV1_LIMIT_DEF
) (
  input  logic [31:0] i_addr,
  output logic        o_hit0_c,
  output logic        o_hit1_c,
  output logic        o_misaligned_c
);

  assign o_hit0_c       = (i_addr >= DEV0_BASE) && (i_addr <= DEV0_LIMIT);
  assign o_hit1_c       = (i_addr >= DEV1_BASE) && (i_addr <= DEV1_LIMIT);
  assign o_misaligned_c = (i_addr[1:0] != 2'b00);

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus with address decode,
// device req/ack handshake, timeout and error return to the winning master.
module pr_bus_arbiter
  import pr_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE  = DEV0_BASE_DEF,
  parameter logic [31:0] DEV0_LIMIT = DEV0_LIMIT_DEF,
  parameter logic [31:0] DEV1_BASE  = DEV1_BASE_DEF,
  parameter logic [31:0] DEV1_LIMIT = DEV1_LIMIT_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wd,
  input  logic        i_m0_we,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rd,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wd,
  input  logic        i_m1_we,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rd,
  output logic [1:0]  o_dev_sel,
  output logic [31:0] o_dev_addr,
  output logic [31:0] o_dev_wd,
  output logic        o_dev_we,
  input  logic [1:0]  i_dev_ack,
  input  logic [31:0] i_dev0_rd,
  input  logic [31:0] i_dev1_rd,
  output logic        o_busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  logic               r_last_grant;
  logic               r_win;
  logic               r_we;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_ack;
  logic [1:0]         r_err;
  logic [31:0]        r_rd0;
  logic [31:0]        r_rd1;
  logic [1:0]         r_dev_sel;
  logic [31:0]        r_dev_addr;
  logic [31:0]        r_dev_wd;
  logic               r_dev_we;
  logic               r_busy;

  logic               w_win;
  logic [31:0]        w_addr;
  logic [31:0]        w_wd;
  logic               w_we;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_misaligned;
  logic               w_dec_ok;
  logic               w_sel_ack;
  logic [31:0]        w_sel_rd;
  logic [31:0]        w_resp_rd;

  // Round-robin: on contention the master that did not win last time goes.
  assign w_win  = (i_m0_req && i_m1_req) ? ~r_last_grant : i_m1_req;
  assign w_addr = w_win ? i_m1_addr : i_m0_addr;
  assign w_wd   = w_win ? i_m1_wd   : i_m0_wd;
  assign w_we   = w_win ? i_m1_we   : i_m0_we;

  pr_addr_decode #(
    .DEV0_BASE  (DEV0_BASE),
    .DEV0_LIMIT (DEV0_LIMIT),
    .DEV1_BASE  (DEV1_BASE),
    .DEV1_LIMIT (DEV1_LIMIT)
  ) u_decode (
    .i_addr         (w_addr),
    .o_hit0_c       (w_hit0),
    .o_hit1_c       (w_hit1),
    .o_misaligned_c (w_misaligned)
  );

  assign w_dec_ok  = !w_misaligned && (w_hit0 || w_hit1);
  assign w_sel_ack = |(i_dev_ack & r_dev_sel);
  assign w_sel_rd  = r_dev_sel[0] ? i_dev0_rd : i_dev1_rd;
  assign w_resp_rd = r_we ? 32'h0 : w_sel_rd;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= MID_M1;
      r_win        <= MID_M0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_ack        <= 2'b00;
      r_err        <= 2'b00;
      r_rd0        <= 32'h0;
      r_rd1        <= 32'h0;
      r_dev_sel    <= 2'b00;
      r_dev_addr   <= 32'h0;
      r_dev_wd     <= 32'h0;
      r_dev_we     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_m0_req || i_m1_req) begin
            r_win  <= w_win;
            r_we   <= w_we;
            r_busy <= 1'b1;
            if (w_dec_ok) begin
              r_state    <= ST_WAIT;
              r_cnt      <= '0;
              r_dev_sel  <= w_hit0 ? 2'b01 : 2'b10;
              r_dev_addr <= word_addr(w_addr);
              r_dev_wd   <= w_wd;
              r_dev_we   <= w_we;
            end else begin
              // Decode miss or misalignment: answer without touching a device.
              r_state      <= ST_RESP;
              r_ack[w_win] <= 1'b1;
              r_err[w_win] <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (w_sel_ack) begin
            r_state      <= ST_RESP;
            r_ack[r_win] <= 1'b1;
            r_err[r_win] <= 1'b0;
            r_dev_sel    <= 2'b00;
            r_dev_we     <= 1'b0;
            if (r_win == MID_M0) r_rd0 <= w_resp_rd;
            else                 r_rd1 <= w_resp_rd;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state      <= ST_RESP;
            r_ack[r_win] <= 1'b1;
            r_err[r_win] <= 1'b1;
            r_dev_sel    <= 2'b00;
            r_dev_we     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_last_grant <= r_win;
          r_ack        <= 2'b00;
          r_err        <= 2'b00;
          r_rd0        <= 32'h0;
          r_rd1        <= 32'h0;
          r_busy       <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_m0_ack   = r_ack[0];
  assign o_m0_err   = r_err[0];
  assign o_m0_rd    = r_rd0;
  assign o_m1_ack   = r_ack[1];
  assign o_m1_err   = r_err[1];
  assign o_m1_rd    = r_rd1;
  assign o_dev_sel  = r_dev_sel;
  assign o_dev_addr = r_dev_addr;
  assign o_dev_wd   = r_dev_wd;
  assign o_dev_we   = r_dev_we;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Bench for pr_bus_arbiter: transaction-level model schedules each grant's
// completion cycle and results; outputs are compared against it every cycle.
module tb_pr_bus_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [31:0] i_m0_addr, i_m0_wd, i_m1_addr, i_m1_wd;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_rd, o_m1_rd;
  logic [1:0]  o_dev_sel;
  logic [31:0] o_dev_addr, o_dev_wd;
  logic        o_dev_we;
  logic [1:0]  i_dev_ack;
  logic [31:0] i_dev0_rd, i_dev1_rd;
  logic        o_busy;

  always #5 clk = ~clk;

  pr_bus_arbiter dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wd(i_m0_wd), .i_m0_we(i_m0_we),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rd(o_m0_rd),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wd(i_m1_wd), .i_m1_we(i_m1_we),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rd(o_m1_rd),
    .o_dev_sel(o_dev_sel), .o_dev_addr(o_dev_addr), .o_dev_wd(o_dev_wd), .o_dev_we(o_dev_we),
    .i_dev_ack(i_dev_ack), .i_dev0_rd(i_dev0_rd), .i_dev1_rd(i_dev1_rd),
    .o_busy(o_busy)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;

  // Master request state
  bit          pend[2];
  logic [31:0] p_addr[2], p_wd[2];
  bit          p_we[2];

  // Transaction model: accepted in cycle s, completion pulse in cycle t_end
  bit          mb;
  int          s, t_end, w, lg, d, sel;
  bit          dec_ok, m_err, m_we;
  logic [31:0] m_rd, m_daddr, m_wd;

  bit          rnd_en, sticky, force_cafe;
  int          force_d;
  int          req_cyc;

  int          cap_cyc[2];
  logic [31:0] cap_rd[2];
  bit          cap_err[2];
  int          ack_log[$];
  logic [1:0]  cap_sel;
  logic [31:0] cap_da, cap_dwd;
  bit          cap_dwe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom % 10)
      0: return 32'h7F00 + 32'(4 * ($urandom % 3));
      1: return 32'h7F10 + 32'(4 * ($urandom % 3));
      2: return 32'h0000_7F0C;
      3: return 32'h0000_7F1C;
      4: return 32'h0000_7EFC;
      5: return 32'h0000_7F0B;
      6: return 32'h0000_8000;
      7: return 32'h0000_7F08;
      8: return 32'h0000_7F18;
      default: return $urandom;
    endcase
  endfunction

  function automatic int pick_d();
    int r;
    r = int'($urandom % 8);
    if (r < 4) return r;
    if (r == 4) return 14;
    if (r == 5) return 13;
    if (r == 6) return 99;
    return int'($urandom % 6);
  endfunction

  task automatic check();
    bit         eb, ea0, ea1;
    logic [1:0] es;
    eb  = mb && (cyc > s);
    ea0 = mb && (cyc == t_end) && (w == 0);
    ea1 = mb && (cyc == t_end) && (w == 1);
    es  = (mb && dec_ok && cyc > s && cyc < t_end) ? ((sel == 0) ? 2'b01 : 2'b10) : 2'b00;
    chk("busy", 32'(o_busy), 32'(eb));
    chk("dev_sel", 32'(o_dev_sel), 32'(es));
    if (es != 2'b00) begin
      chk("dev_we", 32'(o_dev_we), 32'(m_we));
      chk("dev_addr", o_dev_addr, m_daddr);
      chk("dev_wd", o_dev_wd, m_wd);
    end else begin
      chk("dev_we_idle", 32'(o_dev_we), 32'h0);
    end
    chk("m0_ack", 32'(o_m0_ack), 32'(ea0));
    chk("m1_ack", 32'(o_m1_ack), 32'(ea1));
    if (ea0) begin
      chk("m0_err", 32'(o_m0_err), 32'(m_err));
      chk("m0_rd", o_m0_rd, m_rd);
      chk("m1_rd_other", o_m1_rd, 32'h0);
    end
    if (ea1) begin
      chk("m1_err", 32'(o_m1_err), 32'(m_err));
      chk("m1_rd", o_m1_rd, m_rd);
      chk("m0_rd_other", o_m0_rd, 32'h0);
    end
    if (o_m0_ack) begin cap_cyc[0] = cyc; cap_rd[0] = o_m0_rd; cap_err[0] = o_m0_err; ack_log.push_back(0); end
    if (o_m1_ack) begin cap_cyc[1] = cyc; cap_rd[1] = o_m1_rd; cap_err[1] = o_m1_err; ack_log.push_back(1); end
    if (o_dev_sel != 2'b00) begin
      cap_sel = o_dev_sel; cap_da = o_dev_addr; cap_dwd = o_dev_wd; cap_dwe = o_dev_we;
    end
  endtask

  task automatic accept();
    logic [31:0] a;
    bit h0, h1;
    s = cyc;
    if (pend[0] && pend[1]) w = (lg == 0) ? 1 : 0;
    else                    w = pend[0] ? 0 : 1;
    lg      = w;
    a       = p_addr[w];
    m_we    = p_we[w];
    m_wd    = p_wd[w];
    m_daddr = a & 32'hFFFF_FFFC;
    h0      = (a >= 32'h7F00) && (a <= 32'h7F0B);
    h1      = (a >= 32'h7F10) && (a <= 32'h7F1B);
    dec_ok  = (a[1:0] == 2'b00) && (h0 || h1);
    sel     = h0 ? 0 : 1;
    m_rd    = 32'h0;
    if (!dec_ok) begin
      t_end = s + 1; m_err = 1'b1;
    end else begin
      d = (force_d >= 0) ? force_d : pick_d();
      if (d <= 14) begin t_end = s + 2 + d; m_err = 1'b0; end
      else         begin t_end = s + 16;    m_err = 1'b1; end
    end
    mb = 1'b1;
  endtask

  task automatic drive();
    bit         acc_ok;
    logic [1:0] ack;
    acc_ok = !mb;
    if (mb && cyc == t_end) begin
      pend[w] = sticky;
      mb      = 1'b0;
    end
    if (rnd_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1; p_addr[i] = pick_addr(); p_wd[i] = $urandom; p_we[i] = ($urandom % 2) == 1;
        end
      end
    end
    i_m0_req = pend[0]; i_m0_addr = p_addr[0]; i_m0_wd = p_wd[0]; i_m0_we = p_we[0];
    i_m1_req = pend[1]; i_m1_addr = p_addr[1]; i_m1_wd = p_wd[1]; i_m1_we = p_we[1];
    if (acc_ok && (pend[0] || pend[1])) accept();
    i_dev0_rd = force_cafe ? 32'h0000_CAFE : $urandom;
    i_dev1_rd = $urandom;
    ack = 2'($urandom % 4);
    if (mb && dec_ok) begin
      ack[sel] = (d <= 14) && (cyc == s + 1 + d);
      if (ack[sel]) m_rd = m_we ? 32'h0 : ((sel == 0) ? i_dev0_rd : i_dev1_rd);
    end
    i_dev_ack = ack;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    check();
    drive();
  endtask

  task automatic run_until_idle();
    int n = 0;
    do begin cycle(); n++; end while ((mb || pend[0] || pend[1]) && n < 300);
    if (n >= 300) chk("idle_budget", 32'(n), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_sel"}, 32'(o_dev_sel), 32'h0);
    chk({tag, "_we"}, 32'(o_dev_we), 32'h0);
    chk({tag, "_daddr"}, o_dev_addr, 32'h0);
    chk({tag, "_dwd"}, o_dev_wd, 32'h0);
    chk({tag, "_acks"}, 32'({o_m0_ack, o_m1_ack}), 32'h0);
    chk({tag, "_errs"}, 32'({o_m0_err, o_m1_err}), 32'h0);
    chk({tag, "_rd0"}, o_m0_rd, 32'h0);
    chk({tag, "_rd1"}, o_m1_rd, 32'h0);
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] wd, input bit we);
    pend[m] = 1'b1; p_addr[m] = a; p_wd[m] = wd; p_we[m] = we;
    cap_cyc[m] = -1;
    req_cyc = cyc + 1;
  endtask

  initial begin
    int n;
    i_reset = 1'b0;
    i_m0_req = 0; i_m0_addr = 0; i_m0_wd = 0; i_m0_we = 0;
    i_m1_req = 0; i_m1_addr = 0; i_m1_wd = 0; i_m1_we = 0;
    i_dev_ack = 0; i_dev0_rd = 0; i_dev1_rd = 0;
    pend = '{0, 0}; p_addr = '{0, 0}; p_wd = '{0, 0}; p_we = '{0, 0};
    mb = 0; lg = 1; s = 0; t_end = 0; w = 0; d = 0; sel = 0; dec_ok = 0;
    rnd_en = 0; sticky = 0; force_cafe = 0; force_d = -1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    i_reset = 1'b1;

    // Both masters from reset: M0 first, then alternate
    force_d = 0; sticky = 1;
    req(0, 32'h7F10, 32'h0, 1'b0);
    req(1, 32'h7F10, 32'h0, 1'b0);
    n = 0;
    while (ack_log.size() < 4 && n < 60) begin cycle(); n++; end
    if (ack_log.size() < 4) chk("rr_budget", 32'(ack_log.size()), 32'd4);
    else begin
      chk("rr_0", 32'(ack_log[0]), 32'd0);
      chk("rr_1", 32'(ack_log[1]), 32'd1);
      chk("rr_2", 32'(ack_log[2]), 32'd0);
      chk("rr_3", 32'(ack_log[3]), 32'd1);
    end
    sticky = 0;
    run_until_idle();

    // Simple read from device 0
    force_cafe = 1;
    req(0, 32'h7F04, 32'h0, 1'b0);
    run_until_idle();
    chk("t1_lat", 32'(cap_cyc[0] - req_cyc), 32'd2);
    chk("t1_rd", cap_rd[0], 32'h0000_CAFE);
    chk("t1_err", 32'(cap_err[0]), 32'h0);
    force_cafe = 0;

    // M1 write to device 1
    force_d = 2; cap_sel = 0;
    req(1, 32'h7F14, 32'h1234, 1'b1);
    run_until_idle();
    chk("t3_sel", 32'(cap_sel), 32'h2);
    chk("t3_daddr", cap_da, 32'h7F14);
    chk("t3_dwd", cap_dwd, 32'h1234);
    chk("t3_dwe", 32'(cap_dwe), 32'h1);
    chk("t3_err", 32'(cap_err[1]), 32'h0);
    chk("t3_rd", cap_rd[1], 32'h0);

    // Decode miss and misalignment
    cap_sel = 0;
    req(0, 32'h0000_8000, 32'h0, 1'b0);
    run_until_idle();
    chk("t4a_lat", 32'(cap_cyc[0] - req_cyc), 32'd1);
    chk("t4a_err", 32'(cap_err[0]), 32'h1);
    req(0, 32'h0000_7F02, 32'h0, 1'b0);
    run_until_idle();
    chk("t4b_lat", 32'(cap_cyc[0] - req_cyc), 32'd1);
    chk("t4b_err", 32'(cap_err[0]), 32'h1);
    chk("t4_sel", 32'(cap_sel), 32'h0);

    // Timeout with stray acks on the other device
    force_d = 99;
    req(0, 32'h7F00, 32'h0, 1'b0);
    run_until_idle();
    chk("t5_lat", 32'(cap_cyc[0] - req_cyc), 32'd16);
    chk("t5_err", 32'(cap_err[0]), 32'h1);
    chk("t5_rd", cap_rd[0], 32'h0);

    // Reset in the middle of WAIT
    req(0, 32'h7F00, 32'h0, 1'b0);
    n = 0;
    do begin cycle(); n++; end while (!(mb && cyc == s + 5) && n < 50);
    if (n >= 50) chk("t6_budget", 32'(n), 32'd0);
    #2;
    i_reset = 1'b0;
    #1;
    chk_all_zero("t6");
    mb = 0; lg = 1; pend = '{0, 0};
    i_m0_req = 0; i_m1_req = 0; i_dev_ack = 0;
    cap_cyc[0] = -1;
    @(posedge clk);
    #1;
    cyc++;
    check();
    i_reset = 1'b1;
    force_d = 0;
    pend[0] = 1'b1; p_addr[0] = 32'h7F04; p_we[0] = 1'b0;
    req_cyc = cyc;
    drive();
    run_until_idle();
    chk("t6_lat", 32'(cap_cyc[0] - req_cyc), 32'd2);

    // Randomized traffic
    force_d = -1; rnd_en = 1;
    repeat (3000) cycle();
    rnd_en = 0;
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
